// File: rtl/id_ctrl_pkg.sv
// Shared types and constants for the ID-stage issue controller.
package id_ctrl_pkg;

  // Width of an architectural register index (x0..x31).
  localparam int REG_IDX_W = 5;

  // Issue FSM states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    M_BUSY    = 2'd1,
    CSR_DRAIN = 2'd2
  } issue_state_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one saturating-free counter per architectural
// register, plus a total in-flight counter.
// x0 is never tracked; its counter is tied to zero.
module reg_scoreboard
  import id_ctrl_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int CNT_W  = 2,
  parameter int INFL_W = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_clr,
  input  logic                 i_inc_en,
  input  logic [REG_IDX_W-1:0] i_inc_rd,
  input  logic                 i_dec_en,
  input  logic [REG_IDX_W-1:0] i_dec_rd,
  input  logic [REG_IDX_W-1:0] i_rs1,
  input  logic [REG_IDX_W-1:0] i_rs2,
  input  logic [REG_IDX_W-1:0] i_rd,
  output logic                 o_rs1_busy,
  output logic                 o_rs2_busy,
  output logic                 o_rd_sat,
  output logic                 o_full,
  output logic                 o_empty
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [INFL_W-1:0] INFL_MAX = '1;

  logic [NREGS-1:0][CNT_W-1:0] w_cnt;
  logic [NREGS-1:0]            w_inc_hit;
  logic [NREGS-1:0]            w_dec_hit;
  logic [INFL_W-1:0]           r_total;
  logic                        w_tot_inc;
  logic                        w_tot_dec;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign w_inc_hit[gi] = 1'b0;
        assign w_dec_hit[gi] = 1'b0;
        assign w_cnt[gi]     = '0;
      end else begin : g_trk
        logic [CNT_W-1:0] r_cnt;

        assign w_inc_hit[gi] = i_inc_en && (i_inc_rd == REG_IDX_W'(gi));
        // A writeback to an idle register is ignored so the counter cannot wrap.
        assign w_dec_hit[gi] = i_dec_en && (i_dec_rd == REG_IDX_W'(gi)) && (r_cnt != '0);
        assign w_cnt[gi]     = r_cnt;

        // Per-register pending count; simultaneous issue and retire cancel out.
        always_ff @(posedge i_clk or negedge i_rstn) begin
          if (!i_rstn) begin
            r_cnt <= '0;
          end else if (i_clr) begin
            r_cnt <= '0;
          end else if (w_inc_hit[gi] && !w_dec_hit[gi]) begin
            r_cnt <= r_cnt + 1'b1;
          end else if (w_dec_hit[gi] && !w_inc_hit[gi]) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
      end
    end
  endgenerate

  assign w_tot_inc = |w_inc_hit;
  assign w_tot_dec = |w_dec_hit;

  // Total writes in flight across all registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_total <= '0;
    end else if (i_clr) begin
      r_total <= '0;
    end else if (w_tot_inc && !w_tot_dec) begin
      r_total <= r_total + 1'b1;
    end else if (w_tot_dec && !w_tot_inc) begin
      r_total <= r_total - 1'b1;
    end
  end

  // Lookups for the instruction currently in ID.
  always_comb begin
    o_rs1_busy = (w_cnt[i_rs1] != '0);
    o_rs2_busy = (w_cnt[i_rs2] != '0);
    o_rd_sat   = (w_cnt[i_rd] == CNT_MAX);
    o_full     = (r_total == INFL_MAX);
    o_empty    = (r_total == '0);
  end

  // Retiring a register with nothing pending means writeback and issue disagree.
  a_no_underflow : assert property (
    @(posedge i_clk) disable iff (!i_rstn)
    (i_dec_en && (i_dec_rd != '0) && !i_clr) |-> (w_cnt[i_dec_rd] != '0)
  );

endmodule

// File: rtl/id_issue_ctrl.sv
// Issue/stall controller for the decode stage: RAW/WAW-saturation hazard
// detection against the scoreboard, plus serialisation of CSR and M ops.
module id_issue_ctrl
  import id_ctrl_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int CNT_W  = 2,
  parameter int INFL_W = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_id_valid,
  input  logic [REG_IDX_W-1:0] i_rs1,
  input  logic [REG_IDX_W-1:0] i_rs2,
  input  logic                 i_rs1_used,
  input  logic                 i_rs2_used,
  input  logic [REG_IDX_W-1:0] i_rd,
  input  logic                 i_regwrite,
  input  logic                 i_csr_en,
  input  logic                 i_m_en,
  input  logic                 i_wb_valid,
  input  logic [REG_IDX_W-1:0] i_wb_rd,
  input  logic                 i_m_done,
  input  logic                 i_flush,
  output logic                 o_stall,
  output logic                 o_issue,
  output logic                 o_m_start,
  output logic                 o_busy
);

  issue_state_e r_state;
  issue_state_e w_state_next;

  logic w_rs1_busy;
  logic w_rs2_busy;
  logic w_rd_sat;
  logic w_sb_full;
  logic w_sb_empty;
  logic w_raw;
  logic w_waw_sat;
  logic w_issue_ok;

  reg_scoreboard #(
    .NREGS  (NREGS),
    .CNT_W  (CNT_W),
    .INFL_W (INFL_W)
  ) u_sb (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_clr      (i_flush),
    .i_inc_en   (o_issue && i_regwrite),
    .i_inc_rd   (i_rd),
    .i_dec_en   (i_wb_valid),
    .i_dec_rd   (i_wb_rd),
    .i_rs1      (i_rs1),
    .i_rs2      (i_rs2),
    .i_rd       (i_rd),
    .o_rs1_busy (w_rs1_busy),
    .o_rs2_busy (w_rs2_busy),
    .o_rd_sat   (w_rd_sat),
    .o_full     (w_sb_full),
    .o_empty    (w_sb_empty)
  );

  // Hazard evaluation for the instruction in ID; x0 never creates a dependency.
  always_comb begin
    w_raw      = (i_rs1_used && (i_rs1 != '0) && w_rs1_busy) ||
                 (i_rs2_used && (i_rs2 != '0) && w_rs2_busy);
    w_waw_sat  = i_regwrite && (i_rd != '0) && w_rd_sat;
    w_issue_ok = i_id_valid && !w_raw && !w_waw_sat && !w_sb_full && !i_flush &&
                 (!i_csr_en || w_sb_empty);
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state: flush always returns to IDLE; a CSR takes priority over M.
  always_comb begin
    w_state_next = r_state;
    if (i_flush) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (o_issue && i_csr_en) begin
            w_state_next = CSR_DRAIN;
          end else if (o_issue && i_m_en) begin
            w_state_next = M_BUSY;
          end
        end
        M_BUSY: begin
          if (i_m_done) begin
            w_state_next = IDLE;
          end
        end
        CSR_DRAIN: begin
          if (w_sb_empty) begin
            w_state_next = IDLE;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // FSM outputs: combinational issue; reset forces all outputs low at once.
  always_comb begin
    o_issue   = i_rstn && (r_state == IDLE) && w_issue_ok;
    o_m_start = o_issue && i_m_en && !i_csr_en;
    o_stall   = i_rstn && i_id_valid && !o_issue;
    o_busy    = !w_sb_empty || (r_state != IDLE);
  end

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed bench for id_issue_ctrl with an issue scoreboard and monitor.
module tb_id_issue_ctrl;

  logic       clk;
  logic       rstn;
  logic       id_valid;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       rs1_used;
  logic       rs2_used;
  logic [4:0] rd;
  logic       regwrite;
  logic       csr_en;
  logic       m_en;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       m_done;
  logic       flush;
  logic       stall;
  logic       issue;
  logic       m_start;
  logic       busy;

  typedef struct {
    int   cyc;
    logic ms;
    int   tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  id_issue_ctrl #(.NREGS(32), .CNT_W(2), .INFL_W(3)) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_id_valid (id_valid),
    .i_rs1      (rs1),
    .i_rs2      (rs2),
    .i_rs1_used (rs1_used),
    .i_rs2_used (rs2_used),
    .i_rd       (rd),
    .i_regwrite (regwrite),
    .i_csr_en   (csr_en),
    .i_m_en     (m_en),
    .i_wb_valid (wb_valid),
    .i_wb_rd    (wb_rd),
    .i_m_done   (m_done),
    .i_flush    (flush),
    .o_stall    (stall),
    .o_issue    (issue),
    .o_m_start  (m_start),
    .o_busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  // Monitor: every issue the DUT presents is matched against the expected queue.
  always @(negedge clk) begin
    if (rstn) begin
      n_tests++;
      if (m_start && !issue) begin
        n_fail++;
        $display("FAIL m_start_alone: got m_start 1 issue 0 expected m_start 0 at cycle %0d", cyc);
      end
      if (issue) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_issue: got issue at cycle %0d expected none", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.cyc != cyc || mon_e.ms !== m_start) begin
            n_fail++;
            $display("FAIL issue_tag%0d: got cycle %0d m_start %0b expected cycle %0d m_start %0b",
                     mon_e.tag, cyc, m_start, mon_e.cyc, mon_e.ms);
          end
        end
      end
    end
  end

  task automatic set_inst(input logic v, input logic [4:0] s1, input logic u1,
                          input logic [4:0] s2, input logic u2, input logic [4:0] d,
                          input logic rw, input logic csr, input logic m);
    id_valid = v;  rs1 = s1; rs1_used = u1; rs2 = s2; rs2_used = u2;
    rd = d; regwrite = rw; csr_en = csr; m_en = m;
  endtask

  task automatic clr_inst();
    set_inst(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_wb(input logic v, input logic [4:0] r);
    wb_valid = v;
    wb_rd    = r;
  endtask

  task automatic expect_issue(input int tag, input logic ms);
    exp_q.push_back('{cyc, ms, tag});
  endtask

  // One cycle: sample at the falling edge, then advance past the next rising edge.
  task automatic cyc_chk(input string name, input logic ei, input logic es, input logic eb);
    @(negedge clk);
    chk({name, ".issue"}, issue, ei);
    chk({name, ".stall"}, stall, es);
    chk({name, ".busy"},  busy,  eb);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; flush = 1'b0; m_done = 1'b0;
    set_wb(1'b0, 5'd0);
    // Valid instruction held during reset must not stall or issue.
    set_inst(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("reset.stall", stall, 1'b0);
    chk("reset.issue", issue, 1'b0);
    chk("reset.m_start", m_start, 1'b0);
    chk("reset.busy", busy, 1'b0);
    clr_inst();
    @(posedge clk); #1;
    rstn = 1'b1;

    // 1: independent ALU ops back to back, plus an x0 destination
    set_inst(1, 5'd0, 1, 5'd0, 0, 5'd5, 1, 0, 0); expect_issue(1, 0); cyc_chk("t1_a", 1, 0, 0);
    set_inst(1, 5'd6, 1, 5'd7, 1, 5'd8, 1, 0, 0); expect_issue(2, 0); cyc_chk("t1_b", 1, 0, 1);
    set_inst(1, 5'd0, 1, 5'd0, 1, 5'd0, 1, 0, 0); expect_issue(3, 0); cyc_chk("t1_x0", 1, 0, 1);
    clr_inst();
    set_wb(1, 5'd5); cyc_chk("t1_wb5", 0, 0, 1);
    set_wb(1, 5'd8); cyc_chk("t1_wb8", 0, 0, 1);
    set_wb(0, 5'd0); cyc_chk("t1_drained", 0, 0, 0);

    // 2: load-use RAW, released the cycle after writeback
    set_inst(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 0, 0); expect_issue(4, 0); cyc_chk("t2_ld", 1, 0, 0);
    set_inst(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0);
    cyc_chk("t2_raw0", 0, 1, 1);
    cyc_chk("t2_raw1", 0, 1, 1);
    set_wb(1, 5'd5); cyc_chk("t2_wbcyc", 0, 1, 1);
    set_wb(0, 5'd0); expect_issue(5, 0); cyc_chk("t2_go", 1, 0, 0);
    clr_inst();
    set_wb(1, 5'd6); cyc_chk("t2_wb6", 0, 0, 1);
    set_wb(0, 5'd0);

    // 3: mul launches the M unit; dependent-free follower waits for m_done
    set_inst(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 1); expect_issue(6, 1); cyc_chk("t3_mul", 1, 0, 0);
    set_inst(1, 5'd1, 1, 5'd2, 1, 5'd4, 1, 0, 0);
    cyc_chk("t3_busy0", 0, 1, 1);
    cyc_chk("t3_busy1", 0, 1, 1);
    cyc_chk("t3_busy2", 0, 1, 1);
    m_done = 1'b1; cyc_chk("t3_mdone", 0, 1, 1);
    m_done = 1'b0; expect_issue(7, 0); cyc_chk("t3_go", 1, 0, 1);
    clr_inst();
    set_wb(1, 5'd3); cyc_chk("t3_wb3", 0, 0, 1);
    set_wb(1, 5'd4); cyc_chk("t3_wb4", 0, 0, 1);
    set_wb(0, 5'd0);

    // 4: CSR waits for an empty pipeline, then drains its own write
    set_inst(1, 5'd0, 1, 5'd0, 0, 5'd10, 1, 0, 0); expect_issue(8, 0); cyc_chk("t4_a", 1, 0, 0);
    set_inst(1, 5'd0, 1, 5'd0, 0, 5'd11, 1, 0, 0); expect_issue(9, 0); cyc_chk("t4_b", 1, 0, 1);
    set_inst(1, 5'd1, 1, 5'd0, 0, 5'd2, 1, 1, 0);
    cyc_chk("t4_csr_wait", 0, 1, 1);
    set_wb(1, 5'd10); cyc_chk("t4_csr_wb10", 0, 1, 1);
    set_wb(1, 5'd11); cyc_chk("t4_csr_wb11", 0, 1, 1);
    set_wb(0, 5'd0); expect_issue(10, 0); cyc_chk("t4_csr_go", 1, 0, 0);
    set_inst(1, 5'd0, 1, 5'd0, 0, 5'd12, 1, 0, 0);
    cyc_chk("t4_drain0", 0, 1, 1);
    cyc_chk("t4_drain1", 0, 1, 1);
    set_wb(1, 5'd2); cyc_chk("t4_drain_wb", 0, 1, 1);
    set_wb(0, 5'd0); cyc_chk("t4_drain_last", 0, 1, 1);
    expect_issue(11, 0); cyc_chk("t4_go", 1, 0, 0);
    clr_inst();
    set_wb(1, 5'd12); cyc_chk("t4_wb12", 0, 0, 1);
    set_wb(0, 5'd0);

    // 5: per-register counter saturation; issue+wb to same rd nets to zero
    set_inst(1, 5'd0, 1, 5'd0, 0, 5'd9, 1, 0, 0);
    expect_issue(12, 0); cyc_chk("t5_w1", 1, 0, 0);
    expect_issue(13, 0); cyc_chk("t5_w2", 1, 0, 1);
    expect_issue(14, 0); cyc_chk("t5_w3", 1, 0, 1);
    cyc_chk("t5_sat", 0, 1, 1);
    set_wb(1, 5'd9); cyc_chk("t5_sat_wb", 0, 1, 1);
    expect_issue(15, 0); cyc_chk("t5_w4", 1, 0, 1);
    clr_inst();
    cyc_chk("t5_d1", 0, 0, 1);
    cyc_chk("t5_d2", 0, 0, 1);
    set_wb(0, 5'd0); cyc_chk("t5_drained", 0, 0, 0);

    // 6: flush during M_BUSY with writes in flight, then async reset mid-op
    set_inst(1, 5'd0, 1, 5'd0, 0, 5'd13, 1, 0, 0); expect_issue(16, 0); cyc_chk("t6_a", 1, 0, 0);
    set_inst(1, 5'd1, 1, 5'd2, 1, 5'd14, 1, 0, 1); expect_issue(17, 1); cyc_chk("t6_mul", 1, 0, 1);
    set_inst(1, 5'd13, 1, 5'd14, 1, 5'd15, 1, 0, 0);
    cyc_chk("t6_stall", 0, 1, 1);
    flush = 1'b1; m_done = 1'b1; set_wb(1, 5'd13);
    cyc_chk("t6_flush", 0, 1, 1);
    flush = 1'b0; m_done = 1'b0; set_wb(0, 5'd0);
    expect_issue(18, 0); cyc_chk("t6_after", 1, 0, 0);
    set_inst(1, 5'd0, 0, 5'd0, 0, 5'd20, 1, 0, 1);
    #1;
    chk("t6_pre_issue", issue, 1'b1);
    chk("t6_pre_mstart", m_start, 1'b1);
    rstn = 1'b0;
    #1;
    chk("t6_rst.issue", issue, 1'b0);
    chk("t6_rst.stall", stall, 1'b0);
    chk("t6_rst.m_start", m_start, 1'b0);
    chk("t6_rst.busy", busy, 1'b0);
    clr_inst();
    @(posedge clk); #1;
    rstn = 1'b1;
    cyc_chk("t6_post_reset", 0, 0, 0);

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_issues: got %0d unmatched expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
